lemon_mem_arbiter: RTL and testbench

Shares the single 64-bit DPI-backed memory port between two requesters: instruction fetch (IF) and load/store (LS). Each requester uses a valid/ready request channel and a valid/ready response channel. A 3-state FSM serialises accesses and registers memory read data. Load/store has priority, and a starvation counter guarantees fetch progress. Sits between the PC/fetch logic, the LSU and the memory wrapper.

---
 rtl/lemon_pkg.sv | 24 ++
 rtl/lemon_arb_prio.sv | 52 +++++
 rtl/lemon_mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_lemon_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lemon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lemon_pkg
//  Description : Shared types and constants for the lemon memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package lemon_pkg;

    localparam int XLEN   = 64;
    localparam int MASK_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/lemon_arb_prio.sv
`default_nettype none
// ============================================================================
//  Module      : lemon_arb_prio
//  Description : Grant decision between fetch and load/store, with a
//                saturating starvation counter that forces a fetch grant
//                after STARVE_MAX consecutive LS wins while IF waits.
//  Revision    : 1.0 - initial release
// ============================================================================
module lemon_arb_prio
    import lemon_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_if_valid,
    input  logic       i_ls_valid,
    input  arb_state_t i_state,
    output logic       o_grant_if,
    output logic       o_grant_ls
);

    localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

    logic [3:0] r_starve_cnt;
    logic       w_idle;
    logic       w_force_if;

    assign w_idle     = (i_state == IDLE);
    assign w_force_if = (r_starve_cnt == c_starve_max);

    // LS normally wins; a starved fetch wins once the counter reaches its limit
    always_comb begin
        o_grant_ls = w_idle & i_ls_valid & ~(i_if_valid & w_force_if);
        o_grant_if = w_idle & i_if_valid & (~i_ls_valid | w_force_if);
    end

    // Count LS wins that happened while a fetch was waiting; any other grant clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= 4'd0;
        end else if (o_grant_ls && i_if_valid) begin
            if (r_starve_cnt != c_starve_max) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end else if (o_grant_ls || o_grant_if) begin
            r_starve_cnt <= 4'd0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lemon_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : lemon_mem_arbiter
//  Description : Serialises fetch and load/store accesses onto one memory
//                port. IDLE grants, ACCESS drives memory for one cycle and
//                captures read data, RESP holds the response until taken.
//  Revision    : 1.0 - initial release
// ============================================================================
module lemon_mem_arbiter
    import lemon_pkg::*;
#(
    parameter int ADDR_W     = XLEN,
    parameter int DATA_W     = XLEN,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    // instruction fetch
    input  logic                i_if_req_valid,
    output logic                o_if_req_ready,
    input  logic [ADDR_W-1:0]   i_if_req_addr,
    output logic                o_if_resp_valid,
    input  logic                i_if_resp_ready,
    output logic [DATA_W-1:0]   o_if_resp_data,
    // load/store
    input  logic                i_ls_req_valid,
    output logic                o_ls_req_ready,
    input  logic [ADDR_W-1:0]   i_ls_req_addr,
    input  logic                i_ls_req_wen,
    input  logic [DATA_W-1:0]   i_ls_req_wdata,
    input  logic [DATA_W/8-1:0] i_ls_req_wmask,
    output logic                o_ls_resp_valid,
    input  logic                i_ls_resp_ready,
    output logic [DATA_W-1:0]   o_ls_resp_data,
    // memory
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic                o_mem_wen,
    output logic [DATA_W/8-1:0] o_mem_wmask,
    input  logic [DATA_W-1:0]   i_mem_rdata
);

    localparam int c_wm_w = DATA_W / 8;

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    owner_t             r_owner;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_wen;
    logic [DATA_W-1:0]  r_wdata;
    logic [c_wm_w-1:0]  r_wmask;
    logic [DATA_W-1:0]  r_rdata;

    logic w_grant_if;
    logic w_grant_ls;
    logic w_accept;

    lemon_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_if_valid (i_if_req_valid),
        .i_ls_valid (i_ls_req_valid),
        .i_state    (r_state),
        .o_grant_if (w_grant_if),
        .o_grant_ls (w_grant_ls)
    );

    // Grants already include the requester's own valid, so ready == accept.
    // Gating with rst_n keeps both readies low while reset is asserted.
    assign o_if_req_ready = w_grant_if & rst_n;
    assign o_ls_req_ready = w_grant_ls & rst_n;
    assign w_accept       = w_grant_if | w_grant_ls;

    assign o_if_resp_data = r_rdata;
    assign o_ls_resp_data = r_rdata;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-state outputs; memory port is quiet outside ACCESS
    always_comb begin
        w_state_nxt     = r_state;
        o_mem_addr      = '0;
        o_mem_wdata     = '0;
        o_mem_wen       = 1'b0;
        o_mem_wmask     = '0;
        o_if_resp_valid = 1'b0;
        o_ls_resp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                o_mem_addr  = r_addr;
                o_mem_wdata = r_wdata;
                o_mem_wen   = r_wen;
                o_mem_wmask = r_wmask;
                w_state_nxt = RESP;
            end
            RESP: begin
                if (r_owner == OWN_IF) begin
                    o_if_resp_valid = 1'b1;
                    if (i_if_resp_ready) begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    o_ls_resp_valid = 1'b1;
                    if (i_ls_resp_ready) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Request latch on accept; fetches are always reads with an empty mask
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= OWN_IF;
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
        end else if (w_grant_ls) begin
            r_owner <= OWN_LS;
            r_addr  <= i_ls_req_addr;
            r_wen   <= i_ls_req_wen;
            r_wdata <= i_ls_req_wdata;
            r_wmask <= i_ls_req_wmask;
        end else if (w_grant_if) begin
            r_owner <= OWN_IF;
            r_addr  <= i_if_req_addr;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
        end
    end

    // Response register: read data captured in ACCESS, stores acknowledge with 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (r_state == ACCESS) begin
            r_rdata <= r_wen ? '0 : i_mem_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lemon_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lemon_mem_arbiter
//  Description : Self-checking bench for lemon_mem_arbiter with a memory
//                model, directed scenarios and randomized traffic compared
//                against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lemon_mem_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_ready;
    logic [63:0] if_req_addr, if_resp_data;
    logic        ls_req_valid, ls_req_ready, ls_req_wen, ls_resp_valid, ls_resp_ready;
    logic [63:0] ls_req_addr, ls_req_wdata, ls_resp_data;
    logic [7:0]  ls_req_wmask;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_wen;
    logic [7:0]  mem_wmask;

    always #5 clk = ~clk;

    lemon_mem_arbiter #(
        .ADDR_W (64), .DATA_W (64), .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_if_req_valid  (if_req_valid),
        .o_if_req_ready  (if_req_ready),
        .i_if_req_addr   (if_req_addr),
        .o_if_resp_valid (if_resp_valid),
        .i_if_resp_ready (if_resp_ready),
        .o_if_resp_data  (if_resp_data),
        .i_ls_req_valid  (ls_req_valid),
        .o_ls_req_ready  (ls_req_ready),
        .i_ls_req_addr   (ls_req_addr),
        .i_ls_req_wen    (ls_req_wen),
        .i_ls_req_wdata  (ls_req_wdata),
        .i_ls_req_wmask  (ls_req_wmask),
        .o_ls_resp_valid (ls_resp_valid),
        .i_ls_resp_ready (ls_resp_ready),
        .o_ls_resp_data  (ls_resp_data),
        .o_mem_addr      (mem_addr),
        .o_mem_wdata     (mem_wdata),
        .o_mem_wen       (mem_wen),
        .o_mem_wmask     (mem_wmask),
        .i_mem_rdata     (mem_rdata)
    );

    // ---------------- memory wrapper model ----------------
    logic [63:0] mem [0:4095];
    bit          mem_init_done = 1'b0;
    int          wen_cnt = 0;

    assign mem_rdata = mem[mem_addr[14:3]];

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 64'd0;
            mem_init_done <= 1'b1;
        end else if (mem_wen) begin
            for (int b = 0; b < 8; b++)
                if (mem_wmask[b]) mem[mem_addr[14:3]][8*b +: 8] <= mem_wdata[8*b +: 8];
            wen_cnt <= wen_cnt + 1;
        end
    end

    // ---------------- reference model ----------------
    logic [63:0] ref_mem [0:4095];
    int          m_cnt;

    bit          p_if_v, p_ls_v, p_ls_wen;
    logic [63:0] p_if_addr, p_ls_addr, p_ls_wdata;
    logic [7:0]  p_ls_wmask;
    logic [63:0] last_data;

    int checks = 0;
    int errors = 0;

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                          input logic [7:0] wm);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (wm[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic new_ls();
        p_ls_v     = 1'b1;
        p_ls_addr  = 64'h8000_2000 + 64'(8 * $urandom_range(0, 3));
        p_ls_wen   = 1'($urandom % 2);
        p_ls_wdata = {$urandom, $urandom};
        p_ls_wmask = 8'($urandom_range(0, 255));
    endtask

    task automatic new_if();
        p_if_v    = 1'b1;
        p_if_addr = 64'h8000_2000 + 64'(8 * $urandom_range(0, 3));
    endtask

    task automatic drive();
        if_req_valid = p_if_v;
        if_req_addr  = p_if_addr;
        ls_req_valid = p_ls_v;
        ls_req_addr  = p_ls_addr;
        ls_req_wen   = p_ls_wen;
        ls_req_wdata = p_ls_wdata;
        ls_req_wmask = p_ls_wmask;
    endtask

    // One complete transaction; entered and left at a falling edge with the DUT idle
    task automatic run_txn(input int stall, input bit late_ls, output bit won_ls);
        logic [63:0] e_addr, e_wdata, e_data;
        logic        e_wen;
        logic [7:0]  e_mask;
        drive();
        #1;
        won_ls = p_ls_v && !(p_if_v && m_cnt == STARVE_MAX);
        chk("ls_req_ready", ls_req_ready, won_ls);
        chk("if_req_ready", if_req_ready, p_if_v && !won_ls);
        chk("ready_excl", if_req_ready & ls_req_ready, 1'b0);
        chk("idle_mem_quiet", {mem_wen, mem_wmask}, 9'd0);
        if (won_ls) begin
            e_addr  = p_ls_addr;  e_wen  = p_ls_wen;
            e_wdata = p_ls_wdata; e_mask = p_ls_wmask;
            m_cnt   = p_if_v ? ((m_cnt < STARVE_MAX) ? m_cnt + 1 : STARVE_MAX) : 0;
            p_ls_v  = 1'b0;
        end else begin
            e_addr  = p_if_addr;  e_wen  = 1'b0;
            e_wdata = 64'd0;      e_mask = 8'd0;
            m_cnt   = 0;
            p_if_v  = 1'b0;
        end
        e_data = e_wen ? 64'd0 : ref_mem[e_addr[14:3]];
        @(posedge clk);
        @(negedge clk);
        if (late_ls && !p_ls_v) new_ls();
        drive();
        #1;
        chk("acc_mem_addr", mem_addr, e_addr);
        chk("acc_mem_wen", mem_wen, e_wen);
        chk("acc_mem_wdata", mem_wdata, e_wdata);
        chk("acc_mem_wmask", mem_wmask, e_mask);
        chk("acc_no_ready", {if_req_ready, ls_req_ready}, 2'b00);
        if (e_wen) ref_mem[e_addr[14:3]] = merge(ref_mem[e_addr[14:3]], e_wdata, e_mask);
        @(negedge clk);
        #1;
        for (int s = 0; s <= stall; s++) begin
            chk("resp_valid", {if_resp_valid, ls_resp_valid}, won_ls ? 2'b01 : 2'b10);
            chk("resp_data", won_ls ? ls_resp_data : if_resp_data, e_data);
            chk("resp_no_ready", {if_req_ready, ls_req_ready}, 2'b00);
            chk("resp_mem_quiet", {mem_wen, mem_wmask}, 9'd0);
            if (s < stall) begin
                @(negedge clk);
                #1;
            end
        end
        last_data = won_ls ? ls_resp_data : if_resp_data;
        if (won_ls) ls_resp_ready = 1'b1; else if_resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if_resp_ready = 1'b0;
        ls_resp_ready = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        bit          w;
        int          wb;
        logic [9:0]  order;
        rst_n = 1'b0;
        if_req_valid = 1'b1; if_req_addr = 64'd0; if_resp_ready = 1'b0;
        ls_req_valid = 1'b1; ls_req_addr = 64'd0; ls_req_wen = 1'b0;
        ls_req_wdata = 64'd0; ls_req_wmask = 8'd0; ls_resp_ready = 1'b0;
        p_if_v = 0; p_ls_v = 0; p_ls_wen = 0;
        p_if_addr = 0; p_ls_addr = 0; p_ls_wdata = 0; p_ls_wmask = 0;
        m_cnt = 0; last_data = 0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 64'd0;

        // Reset state, even with both valids high
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", {if_req_ready, ls_req_ready}, 2'b00);
        chk("rst_resp_valid", {if_resp_valid, ls_resp_valid}, 2'b00);
        chk("rst_mem", {mem_wen, mem_wmask, mem_addr, mem_wdata}, 137'd0);
        @(negedge clk);
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
        rst_n = 1'b1;

        // Reset in the middle of a store access drops it entirely
        p_ls_v = 1; p_ls_addr = 64'h8000_3000; p_ls_wen = 1;
        p_ls_wdata = 64'hAAAA_5555_AAAA_5555; p_ls_wmask = 8'hFF;
        drive();
        #1;
        chk("mid_rst_accept", ls_req_ready, 1'b1);
        wb = wen_cnt;
        @(posedge clk);
        @(negedge clk);
        p_ls_v = 0; drive();
        #1;
        chk("mid_rst_access_wen", mem_wen, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_off", {mem_wen, mem_wmask, mem_addr, mem_wdata}, 137'd0);
        chk("mid_rst_outputs", {if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid}, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("post_rst_no_resp", {if_resp_valid, ls_resp_valid}, 2'b00);
        end
        chk("post_rst_mem_unchanged", mem[12'h600], 64'd0);
        chk("post_rst_no_write", 64'(wen_cnt - wb), 64'd0);
        @(negedge clk);

        // Preload the fetch word, then fetch it with IF alone
        p_ls_v = 1; p_ls_addr = 64'h8000_0000; p_ls_wen = 1;
        p_ls_wdata = 64'h0010_0093_0000_0513; p_ls_wmask = 8'hFF;
        run_txn(0, 0, w);
        wb = wen_cnt;
        p_if_v = 1; p_if_addr = 64'h8000_0000;
        run_txn(0, 0, w);
        chk("fetch_word", last_data, 64'h0010_0093_0000_0513);
        chk("fetch_no_write", 64'(wen_cnt - wb), 64'd0);

        // Full store then load back
        wb = wen_cnt;
        p_ls_v = 1; p_ls_addr = 64'h8000_1000; p_ls_wen = 1;
        p_ls_wdata = 64'hDEAD_BEEF_CAFE_F00D; p_ls_wmask = 8'hFF;
        run_txn(0, 0, w);
        chk("store_ack_data", last_data, 64'd0);
        chk("store_one_pulse", 64'(wen_cnt - wb), 64'd1);
        p_ls_v = 1; p_ls_wen = 0; p_ls_wmask = 8'h00;
        run_txn(0, 0, w);
        chk("load_back", last_data, 64'hDEAD_BEEF_CAFE_F00D);

        // Partial store touches only the low four bytes
        p_ls_v = 1; p_ls_wen = 1; p_ls_wdata = 64'h1122_3344_5566_7788; p_ls_wmask = 8'h0F;
        run_txn(0, 0, w);
        p_ls_v = 1; p_ls_wen = 0; p_ls_wmask = 8'h00;
        run_txn(0, 0, w);
        chk("partial_readback", last_data, 64'hDEAD_BEEF_5566_7788);

        // Fetch response held for 5 cycles with an LS request waiting
        p_if_v = 1; p_if_addr = 64'h8000_0000;
        run_txn(5, 1, w);
        chk("bp_fetch_data", last_data, 64'h0010_0093_0000_0513);
        run_txn(0, 0, w);
        chk("bp_ls_next_idle", w, 1'b1);

        // Continuous contention: LS x4 then IF, twice
        order = 10'd0;
        for (int g = 0; g < 10; g++) begin
            if (!p_if_v) new_if();
            if (!p_ls_v) new_ls();
            run_txn(0, 0, w);
            order = {order[8:0], w};
        end
        chk("grant_order", order, 10'b1111011110);

        // Randomized traffic with random backpressure
        p_if_v = 0; p_ls_v = 0;
        for (int t = 0; t < 60; t++) begin
            if (!p_if_v && ($urandom % 2 == 1)) new_if();
            if (!p_ls_v && ($urandom % 3 != 0)) new_ls();
            if (!p_if_v && !p_ls_v) new_if();
            run_txn($urandom_range(0, 3), 1'($urandom % 4 == 0), w);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
